// File: rtl/uart_rx_if.sv
// uart_rx byte-side handshake bundle.
// The receiver drives through master; the consumer connects to slave.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, mid-bit sampling, valid/ready byte output.
// Optional: `define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
module uart_rx #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rxd,
  uart_rx_if.master bus
);

  localparam int CPB  = CLK_HZ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;

  localparam logic [CW-1:0] C_FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] C_HALF = CW'(HALF - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          r_s1;
  logic          r_rxd_s;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_pend;
  logic          r_ferr;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ovr;
  logic          w_samp;

`ifdef UART_RX_MAJORITY_EN
  logic r_h1;
  logic r_h2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_h1 <= 1'b1;
      r_h2 <= 1'b1;
    end else begin
      r_h1 <= r_rxd_s;
      r_h2 <= r_h1;
    end
  end

  // sample cycle plus the two cycles before it
  assign w_samp = (r_rxd_s & r_h1) |
                  (r_rxd_s & r_h2) |
                  (r_h1 & r_h2);
`else
  assign w_samp = r_rxd_s;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1    <= 1'b1;
      r_rxd_s <= 1'b1;
    end else begin
      r_s1    <= rxd;
      r_rxd_s <= r_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_pend  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_pend <= 1'b0;
      r_ferr <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!r_rxd_s) r_state <= S_START;
        end
        S_START: begin
          if (r_cnt == C_HALF) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= w_samp ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == C_FULL) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_samp;
            r_idx          <= r_idx + 1'b1;
            if (r_idx == 3'd7) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == C_FULL) begin
            r_cnt <= '0;
            if (w_samp) begin
              r_pend  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_BREAK: begin
          r_cnt <= '0;
          if (r_rxd_s) r_state <= S_IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // a pending byte wins over a plain accept in the same cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (r_pend) begin
        if (!r_valid || bus.rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && bus.rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.rx_data   = r_data;
  assign bus.rx_valid  = r_valid;
  assign bus.frame_err = r_ferr;
  assign bus.overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx.
// Small baud divider (16 clocks/bit) keeps frames short.
module tb_uart_rx;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int HALF   = CPB / 2;
  localparam int LAT    = 2 + HALF + 9 * CPB + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rxd = 1'b1;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_HZ   (CLK_HZ),
    .BAUD_RATE(BAUD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rxd(rxd),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_bad  = 0;
  int cyc    = 0;
  int n_ferr = 0;
  int n_ovr  = 0;
  int n_vcyc = 0;
  int t_rise = -1;
  logic prev_v = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      prev_v = 1'b0;
    end else begin
      if (bus.frame_err) n_ferr++;
      if (bus.overrun) n_ovr++;
      if (bus.frame_err || bus.overrun)
        chk("ferr_ovr_excl", 32'(bus.frame_err & bus.overrun), 0);
      if (bus.rx_valid) n_vcyc++;
      if (bus.rx_valid && !prev_v) t_rise = cyc;
      prev_v = bus.rx_valid;
      if (bus.rx_valid && bus.rx_ready)
        chk("rx_data", 32'(bus.rx_data),
            exp_q.size() != 0 ? 32'(exp_q.pop_front()) : 32'h100);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b,
                      input bit glitch,
                      input bit rst_hit);
    logic [9:0] fr;
    bit aborted;
    fr = {1'b1, b, 1'b0};
    aborted = 1'b0;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < CPB; i++) begin
        if (rst_hit && k == 4) aborted = 1'b1;
        rst = (rst_hit && k == 4 && i < 3) ? 1'b0 : 1'b1;
        if (aborted)
          rxd = 1'b1;
        else if (glitch && k >= 1 && k <= 8 && i == HALF)
          rxd = 1'b1;
        else
          rxd = fr[k];
        step(1);
      end
    end
    rxd = 1'b1;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 4 * CPB;
    while (exp_q.size() != 0 && budget > 0) begin
      step(1);
      budget--;
    end
    chk(tag, 32'(exp_q.size()), 0);
  endtask

  initial begin
    int c0;
    int lat;
    logic [7:0] g_exp;
    bus.rx_ready = 1'b1;
    rst = 1'b0;
    step(3);
    chk("rst_valid", 32'(bus.rx_valid), 0);
    chk("rst_data", 32'(bus.rx_data), 0);
    chk("rst_ferr", 32'(bus.frame_err), 0);
    chk("rst_ovr", 32'(bus.overrun), 0);
    rst = 1'b1;
    step(CPB);

    // basic frame and latency
    n_vcyc = 0;
    t_rise = -1;
    c0 = cyc;
    exp_q.push_back(8'h55);
    send(8'h55, 1'b0, 1'b0);
    step(4);
    lat = t_rise - (c0 + 1);
    chk("t1_latency", 32'(lat >= LAT - 2 && lat <= LAT + 2), 1);
    chk("t1_vcyc", 32'(n_vcyc), 1);
    chk("t1_ferr", 32'(n_ferr), 0);
    chk("t1_ovr", 32'(n_ovr), 0);
    drain("t1_drain");

    // short low glitch shorter than half a bit
    n_vcyc = 0;
    rxd = 1'b0;
    step(HALF - 4);
    rxd = 1'b1;
    step(2 * CPB);
    chk("t2_vcyc", 32'(n_vcyc), 0);
    chk("t2_ferr", 32'(n_ferr), 0);
    exp_q.push_back(8'hA3);
    send(8'hA3, 1'b0, 1'b0);
    drain("t2_drain");

    // break condition
    n_vcyc = 0;
    rxd = 1'b0;
    step(12 * CPB);
    chk("t3_ferr", 32'(n_ferr), 1);
    chk("t3_vcyc", 32'(n_vcyc), 0);
    rxd = 1'b1;
    step(2 * CPB);
    exp_q.push_back(8'h0F);
    send(8'h0F, 1'b0, 1'b0);
    drain("t3_drain");
    chk("t3_ferr_after", 32'(n_ferr), 1);

    // overrun with consumer stalled
    bus.rx_ready = 1'b0;
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 1'b0);
    step(4);
    chk("t4_valid", 32'(bus.rx_valid), 1);
    chk("t4_data", 32'(bus.rx_data), 32'hA5);
    chk("t4_ovr", 32'(n_ovr), 1);
    bus.rx_ready = 1'b1;
    step(1);
    chk("t4_drop", 32'(bus.rx_valid), 0);
    drain("t4_drain");

    // reset mid-frame
    n_vcyc = 0;
    send(8'h7E, 1'b0, 1'b1);
    step(2 * CPB);
    chk("t5_vcyc", 32'(n_vcyc), 0);
    chk("t5_data", 32'(bus.rx_data), 0);
    exp_q.push_back(8'h81);
    send(8'h81, 1'b0, 1'b0);
    drain("t5_drain");

    // one-cycle high glitch at each data sample point
`ifdef UART_RX_MAJORITY_EN
    g_exp = 8'h00;
`else
    g_exp = 8'hFF;
`endif
    exp_q.push_back(g_exp);
    send(8'h00, 1'b1, 1'b0);
    drain("t6_drain");
    step(CPB);
    chk("end_ovr", 32'(n_ovr), 1);
    chk("end_ferr", 32'(n_ferr), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the downstream neighbour of uart_tx, consuming the serial txd line.
- Synchronizes the asynchronous rxd input and detects the start bit.
- Samples 8N1 frames (start, 8 data bits LSB first, 1 stop) at mid-bit using a clock-count bit timer.
- Presents each received byte on a valid/ready handshake, with framing-error and overrun pulses.

Parameters:
clk_hz, 50_000_000, system clock frequency in Hz
baud_rate, 115_200, line rate in bits/s; CLKS_PER_BIT = clk_hz/baud_rate (integer divide, 434 at defaults), HALF_BIT = CLKS_PER_BIT/2 (217)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-low reset (0 = reset, sampled on rising clk)
rxd  input  1  asynchronous serial line, idle high
rx_data  output  8  received byte; valid while rx_valid=1
rx_valid  output  1  byte available; held until accepted
rx_ready  input  1  consumer accepts byte when rx_valid&&rx_ready on a rising edge
frame_err  output  1  1-cycle pulse: stop bit sampled 0
overrun  output  1  1-cycle pulse: new byte completed while previous still unaccepted

Behaviour:
- Reset (rst=0 at edge):
  - state=IDLE; rx_data=8'h00; rx_valid=0; frame_err=0; overrun=0.
  - Both synchronizer flops=1; bit counter and bit index=0.
  - Reset mid-frame aborts the frame with no output.
- Synchronizer: two flops (rxd -> s1 -> rxd_s). All decisions use rxd_s only.
- Timer: counter width ceil(log2(CLKS_PER_BIT)); cleared on every state change.
- IDLE: rxd_s==0 -> START.
- START: at count HALF_BIT-1, sample.
  - Sample 0 -> DATA, bit index 0.
  - Sample 1 -> IDLE (glitch rejected; no flag).
- DATA: at count CLKS_PER_BIT-1, shift the sample into bit[index], LSB first. After index 7 -> STOP.
- STOP: at count CLKS_PER_BIT-1, sample.
  - Sample 1 -> deliver byte, go to IDLE. A new start edge is detectable from the next cycle.
  - Sample 0 -> frame_err=1 for one cycle, byte discarded, go to BREAK.
- BREAK: wait until rxd_s==1, then go to IDLE. A held-low line (break) does not retrigger frames.
- Delivery happens on the cycle after the stop sample:
  - rx_valid=0, or (rx_valid && rx_ready) this cycle: rx_data <= new byte, rx_valid <= 1.
  - rx_valid=1 && rx_ready=0: new byte dropped, rx_data unchanged, overrun=1 for one cycle.
- Accept without a new byte: rx_valid && rx_ready -> rx_valid <= 0 next cycle. rx_data holds its value.
- Latency: first rxd low at the pin -> rx_valid high = 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles. This is 4126 at defaults; the bench accepts ±2.
- rx_ready is ignored while rx_valid=0.
- frame_err and overrun never assert in the same cycle: framing errors deliver no byte.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each START, DATA and STOP sample is the 2-of-3 majority of rxd_s in the sample cycle and the two cycles before it. Sample timing and latency are unchanged.
- Undefined: single sample of rxd_s in the sample cycle.
- Ports are identical in both builds.

Test Plan:
1. uart_tx (same params) drives rxd with 0x55, rx_ready=1 -> rx_valid pulses 1 cycle with rx_data=0x55 within 4126±2 cycles of the start edge. frame_err=0, overrun=0.
2. rxd low for 100 cycles, then high -> START returns to IDLE. No rx_valid, no frame_err. A following 0xA3 frame is received correctly.
3. rxd held low for 12 bit times -> frame_err 1-cycle pulse at the stop sample; no rx_valid; FSM stays in BREAK. After rxd returns high, a 0x0F frame is received.
4. rx_ready=0; send 0xA5 then 0x3C back-to-back -> rx_valid=1, rx_data=0xA5. overrun pulses once at the second delivery. Raise rx_ready -> rx_valid drops next cycle.
5. rst=0 for 3 cycles during data bit 3 of frame 0x7E -> all outputs return to reset values; no byte delivered. The next frame 0x81 is received correctly.
6. With UART_RX_MAJORITY_EN defined, send 0x00 with a 1-cycle high glitch at each data sample point -> rx_data=0x00. The same stimulus without the macro -> rx_data=0xFF.
